// File: rtl/mac_sys_req_master.sv
// mac_sys_req_master: per-port requester that serialises single register
// read/write commands onto the byte-wide MAC management request interface.
module mac_sys_req_master #(
  parameter int DATA_BYTES   = 2,
  parameter int ACK_TIMEOUT  = 255,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_wr,
  input  logic [7:0]              cmd_addr,
  input  logic [8*DATA_BYTES-1:0] cmd_wdata,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic [8*DATA_BYTES-1:0] rsp_rdata,
  output logic                    sys_req_valid,
  output logic                    sys_req_wr,
  output logic [7:0]              sys_req_addr,
  input  logic                    sys_req_ack,
  output logic [7:0]              sys_req_data,
  output logic                    sys_req_data_valid,
  input  logic [7:0]              sys_resp_data,
  input  logic                    sys_resp_data_valid
);

  localparam int DW   = 8 * DATA_BYTES;
  localparam int MAXT = (ACK_TIMEOUT > RESP_TIMEOUT) ? ACK_TIMEOUT : RESP_TIMEOUT;
  localparam int CW   = $clog2(MAXT + 1);
  localparam int BW   = $clog2(DATA_BYTES + 1);

  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] RESP_LAST = CW'(RESP_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [BW-1:0] NBYTES    = BW'(DATA_BYTES);

  typedef enum logic [2:0] {IDLE, REQ, WDATA, RWAIT, DONE} state_t;

  state_t          state_q;
  logic            wr_q;
  logic            err_q;
  logic [DW-1:0]   shift_q;
  logic [BW-1:0]   byte_cnt_q;
  logic [CW-1:0]   wait_cnt_q;
  logic [CW-1:0]   wait_inc;

  logic            cmd_ready_q;
  logic            rsp_valid_q;
  logic            rsp_err_q;
  logic [DW-1:0]   rsp_rdata_q;
  logic            sys_req_valid_q;
  logic            sys_req_wr_q;
  logic [7:0]      sys_req_addr_q;
  logic [7:0]      sys_req_data_q;
  logic            sys_req_data_valid_q;

  // Saturating wait counter so a stuck MAC can never wrap it back to zero.
  assign wait_inc = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q              <= IDLE;
      wr_q                 <= 1'b0;
      err_q                <= 1'b0;
      shift_q              <= '0;
      byte_cnt_q           <= '0;
      wait_cnt_q           <= '0;
      cmd_ready_q          <= 1'b1;
      rsp_valid_q          <= 1'b0;
      rsp_err_q            <= 1'b0;
      rsp_rdata_q          <= '0;
      sys_req_valid_q      <= 1'b0;
      sys_req_wr_q         <= 1'b0;
      sys_req_addr_q       <= '0;
      sys_req_data_q       <= '0;
      sys_req_data_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          if (cmd_valid) begin
            state_q         <= REQ;
            cmd_ready_q     <= 1'b0;
            wr_q            <= cmd_wr;
            err_q           <= 1'b0;
            shift_q         <= cmd_wr ? cmd_wdata : '0;
            byte_cnt_q      <= '0;
            wait_cnt_q      <= '0;
            sys_req_valid_q <= 1'b1;
            sys_req_wr_q    <= cmd_wr;
            sys_req_addr_q  <= cmd_addr;
          end
        end

        REQ: begin
          if (sys_req_ack) begin
            sys_req_valid_q <= 1'b0;
            sys_req_wr_q    <= 1'b0;
            sys_req_addr_q  <= '0;
            wait_cnt_q      <= '0;
            if (wr_q) begin
              // First write byte goes out the cycle right after the ack.
              state_q              <= WDATA;
              sys_req_data_valid_q <= 1'b1;
              sys_req_data_q       <= shift_q[DW-1 -: 8];
              shift_q              <= shift_q << 8;
              byte_cnt_q           <= BW'(1);
            end else begin
              state_q    <= RWAIT;
              byte_cnt_q <= '0;
            end
          end else if (wait_cnt_q >= ACK_LAST) begin
            state_q         <= DONE;
            err_q           <= 1'b1;
            sys_req_valid_q <= 1'b0;
            sys_req_wr_q    <= 1'b0;
            sys_req_addr_q  <= '0;
          end else begin
            wait_cnt_q <= wait_inc;
          end
        end

        WDATA: begin
          if (byte_cnt_q == NBYTES) begin
            state_q              <= DONE;
            err_q                <= 1'b0;
            sys_req_data_valid_q <= 1'b0;
            sys_req_data_q       <= '0;
          end else begin
            sys_req_data_q <= shift_q[DW-1 -: 8];
            shift_q        <= shift_q << 8;
            byte_cnt_q     <= byte_cnt_q + BW'(1);
          end
        end

        RWAIT: begin
          // A byte landing on the timeout cycle wins over the timeout.
          if (sys_resp_data_valid) begin
            shift_q    <= DW'({shift_q, sys_resp_data});
            wait_cnt_q <= '0;
            if (byte_cnt_q == NBYTES - BW'(1)) begin
              state_q <= DONE;
              err_q   <= 1'b0;
            end else begin
              byte_cnt_q <= byte_cnt_q + BW'(1);
            end
          end else if (wait_cnt_q >= RESP_LAST) begin
            state_q <= DONE;
            err_q   <= 1'b1;
          end else begin
            wait_cnt_q <= wait_inc;
          end
        end

        DONE: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_q;
          rsp_rdata_q <= (err_q || wr_q) ? '0 : shift_q;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready          = cmd_ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_err            = rsp_err_q;
  assign rsp_rdata          = rsp_rdata_q;
  assign sys_req_valid      = sys_req_valid_q;
  assign sys_req_wr         = sys_req_wr_q;
  assign sys_req_addr       = sys_req_addr_q;
  assign sys_req_data       = sys_req_data_q;
  assign sys_req_data_valid = sys_req_data_valid_q;

endmodule
